// File: rtl/display_scan_driver.sv
// Time-multiplexed 8-digit hex scan driver. Loads are double-buffered and reach the display only on a frame wrap.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module display_scan_driver #(
    parameter int unsigned COUNT_MAX = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] value,
    input  logic        load,
    input  logic [7:0]  digit_enable,
    output logic [3:0]  bcd_out,
    output logic [7:0]  anodes,
    output logic [2:0]  digit_idx,
    output logic        frame_start,
    output logic        pending
);

    localparam int unsigned CW = (COUNT_MAX > 2) ? $clog2(COUNT_MAX) : 1;

    logic [CW-1:0] counter;
    logic [31:0]   shadow;
    logic [31:0]   pend;
    logic          tick;
    logic          wrap;
    logic [7:0]    lz_blank;

    assign tick = (counter == CW'(COUNT_MAX - 1));
    assign wrap = tick && (digit_idx == 3'd7);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter     <= '0;
            digit_idx   <= '0;
            shadow      <= '0;
            pend        <= '0;
            pending     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            counter     <= tick ? '0 : counter + 1'b1;
            frame_start <= wrap;
            if (tick)
                digit_idx <= digit_idx + 3'd1;
            if (wrap && pending)
                shadow <= pend;
            // A load on the wrap edge refills pend after its old contents move to shadow.
            if (load) begin
                pend    <= value;
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

    assign bcd_out = shadow[{digit_idx, 2'b00} +: 4];

    always_comb begin
        lz_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        for (int unsigned i = 1; i < 8; i++)
            lz_blank[i] = ((shadow >> (4 * i)) == 32'd0);
`endif
    end

    // Reset gating keeps every digit dark while reset_n is low, without waiting for a clock.
    always_comb begin
        anodes = '1;
        if (reset_n && digit_enable[digit_idx] && !lz_blank[digit_idx])
            anodes[digit_idx] = 1'b0;
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench for display_scan_driver with COUNT_MAX = 4: expectations are queued per clock and compared on the falling edge.
module tb_display_scan_driver;

    localparam int unsigned CM = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] value = '0;
    logic        load = 1'b0;
    logic [7:0]  digit_enable = 8'hFF;
    logic [3:0]  bcd_out;
    logic [7:0]  anodes;
    logic [2:0]  digit_idx;
    logic        frame_start;
    logic        pending;

    display_scan_driver #(.COUNT_MAX(CM)) dut (
        .clk(clk), .reset_n(reset_n), .value(value), .load(load),
        .digit_enable(digit_enable), .bcd_out(bcd_out), .anodes(anodes),
        .digit_idx(digit_idx), .frame_start(frame_start), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] idx;
        logic [3:0] bcd;
        logic [7:0] an;
        logic       fs;
        logic       pend;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    int          m_cyc;
    logic [31:0] m_shadow, m_pend;
    logic        m_pending;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [7:0] exp_anodes(input int idx, input logic [7:0] en, input logic [31:0] sh);
        logic [7:0] a;
        logic blank;
        a = 8'hFF;
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && (sh >> (4 * idx)) == 32'd0)
            blank = 1'b1;
`endif
        if (en[idx] && !blank)
            a[idx] = 1'b0;
        return a;
    endfunction

    // One clock: drive inputs, advance the reference model at the edge, queue what the DUT must show.
    task automatic step(input logic ld, input logic [31:0] val);
        exp_t e;
        int idx;
        load  = ld;
        value = val;
        @(posedge clk);
        m_cyc++;
        if (m_cyc % (8 * CM) == 0 && m_pending) begin
            m_shadow  = m_pend;
            m_pending = 1'b0;
        end
        if (ld) begin
            m_pend    = val;
            m_pending = 1'b1;
        end
        idx    = (m_cyc / CM) % 8;
        e.idx  = 3'(idx);
        e.bcd  = 4'((m_shadow >> (4 * idx)) & 32'hF);
        e.an   = exp_anodes(idx, digit_enable, m_shadow);
        e.fs   = (m_cyc % (8 * CM) == 0);
        e.pend = m_pending;
        q.push_back(e);
        @(negedge clk);
        #1;
        load = 1'b0;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("digit_idx",   32'(digit_idx),   32'(e.idx));
            check("bcd_out",     32'(bcd_out),     32'(e.bcd));
            check("anodes",      32'(anodes),      32'(e.an));
            check("frame_start", 32'(frame_start), 32'(e.fs));
            check("pending",     32'(pending),     32'(e.pend));
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    // Run until the next clock edge is the 7->0 wrap edge.
    task automatic to_pre_wrap();
        while (m_cyc % (8 * CM) != 8 * CM - 1) step(1'b0, 32'h0);
    endtask

    task automatic model_reset();
        m_cyc = 0;
        m_shadow = '0;
        m_pend = '0;
        m_pending = 1'b0;
    endtask

    initial begin
        model_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #20;
        check("rst_anodes",  32'(anodes),      32'hFF);
        check("rst_idx",     32'(digit_idx),   32'h0);
        check("rst_bcd",     32'(bcd_out),     32'h0);
        check("rst_pending", 32'(pending),     32'h0);
        check("rst_fs",      32'(frame_start), 32'h0);
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Full first frame, frame_start at cycle 32, and into the next frame.
        idle(40);
        check("first_frame_len", 32'(m_cyc), 32'd40);

        // Mid-frame load held until the wrap.
        step(1'b1, 32'h89ABCDEF);
        to_pre_wrap();
        idle(8 * CM + 2);

        // Two loads before one wrap: only the last is shown.
        idle(5);
        step(1'b1, 32'h11111111);
        idle(6);
        step(1'b1, 32'h22222222);
        to_pre_wrap();
        idle(8 * CM);

        // Load coincident with the wrap while 33333333 is pending.
        step(1'b1, 32'h33333333);
        to_pre_wrap();
        step(1'b1, 32'h44444444);
        check("wrap_load_shadow_digit0", 32'(bcd_out), 32'h3);
        check("wrap_load_pending",       32'(pending), 32'h1);
        to_pre_wrap();
        idle(8 * CM);

        // Enable mask blanks the upper digits.
        digit_enable = 8'h0F;
        idle(8 * CM);
        digit_enable = 8'hA5;
        idle(8 * CM);
        digit_enable = 8'hFF;

        // Value with leading zeros.
        step(1'b1, 32'h00000305);
        to_pre_wrap();
        idle(8 * CM + 1);

        // Reset during digit 5 with a load pending.
        step(1'b1, 32'hDEADBEEF);
        while ((m_cyc / CM) % 8 != 5) step(1'b0, 32'h0);
        check("pre_rst_pending", 32'(pending), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_anodes",  32'(anodes),    32'hFF);
        check("async_pending", 32'(pending),   32'h0);
        check("async_idx",     32'(digit_idx), 32'h0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        check("post_rst_bcd", 32'(bcd_out), 32'h0);
        idle(8 * CM + 4);

        @(negedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scan_driver.md
DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 Parameter COUNT_MAX, default 100000, SHALL set the number of clk cycles each digit is lit (legal range 2..2^20).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 value  input  32  SHALL carry eight 4-bit hex digits; digit i = value[4i+3:4i].
REQ-005 load  input  1  SHALL be a single-cycle strobe that captures value into the pending register.
REQ-006 digit_enable  input  8  SHALL be the per-digit enable mask; 0 blanks that digit.
REQ-007 bcd_out  output  4  SHALL be the nibble of the active digit, fed to the 7-segment decoder stage.
REQ-008 anodes  output  8  SHALL be active-low digit selects, at most one bit low.
REQ-009 digit_idx  output  3  SHALL be the index of the active digit.
REQ-010 frame_start  output  1  SHALL be a one-cycle pulse when digit_idx wraps 7->0.
REQ-011 pending  output  1  SHALL be high while a loaded value awaits transfer to the display.

Function
REQ-012 Tick counter SHALL count 0..COUNT_MAX-1 and wrap to 0; tick = (counter == COUNT_MAX-1).
REQ-013 On tick, digit_idx SHALL increment modulo 8; 7 wraps to 0 with frame_start = 1 in the cycle the new index 0 is registered.
REQ-014 bcd_out SHALL equal shadow[4*digit_idx+3 : 4*digit_idx], combinational from registered state, same cycle as digit_idx.
REQ-015 anodes SHALL be all 1 except bit digit_idx, which is 0 only if digit_enable[digit_idx] = 1.
REQ-016 load = 1 SHALL write value to pend register and set pending = 1 in the next cycle.
REQ-017 On the 7->0 wrap with pending = 1, shadow SHALL take pend and pending SHALL clear; shadow SHALL change at no other time.
REQ-018 load coincident with the 7->0 wrap: old pend SHALL go to shadow (if pending) and new value to pend, with pending = 1 afterwards.
REQ-019 load while pending = 1 (no wrap) SHALL overwrite pend; only the last value before a wrap is displayed.
REQ-020 bcd_out SHALL keep the digit nibble even when the digit is blanked.
REQ-021 digit_enable changes SHALL take effect combinationally, same cycle.

Reset
REQ-022 While reset_n = 0: counter, digit_idx, shadow, pend, pending, frame_start SHALL be 0, and anodes SHALL be 8'hFF.
REQ-023 After reset release, digit 0 SHALL be selected first, displaying 0, and the first frame_start SHALL occur 8*COUNT_MAX cycles later.
REQ-024 Reset asserted mid-frame or with pending = 1 SHALL discard pend immediately, without waiting for a clock edge.

Configuration
REQ-025 With LEADING_ZERO_BLANK_EN defined, the display SHALL blank (anode high) every digit i > 0 whose nibble and all higher nibbles of shadow are 0; digit 0 is never blanked by this rule.
REQ-026 Without LEADING_ZERO_BLANK_EN, only digit_enable SHALL blank digits.

Verification
REQ-027 COUNT_MAX = 4, reset release, enable = FF -> anodes FE,FD,FB,...,7F each for 4 cycles; frame_start pulse at cycle 32.
REQ-028 load value = 32'h89ABCDEF mid-frame -> pending = 1; display unchanged until wrap, then bcd_out = F,E,D,C,B,A,9,8 over digits 0..7; pending = 0.
REQ-029 load 32'h11111111 and then load 32'h22222222 before the wrap -> only 2 is ever shown.
REQ-030 load coincident with the wrap while pending holds 32'h33333333 -> shadow = 33333333, pending stays 1, new value is shown at the next wrap.
REQ-031 digit_enable = 8'h0F -> anodes = FF while digit_idx is 4..7; with LEADING_ZERO_BLANK_EN and shadow = 32'h00000305, digits 3..7 are blanked and digits 0..2 are lit.
REQ-032 reset_n pulsed low during digit 5 with pending = 1 -> anodes = FF asynchronously; after release digit_idx = 0, bcd_out = 0, pending = 0.
